// File: rtl/lab_pkg.sv
// Shared definitions for the operand sequencer lab: default operand width
// and the FSM state encoding seen on the State output.
package lab_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b10,
    SHOW  = 2'b11
  } state_t;

endpackage

// File: rtl/key_press_detect.sv
// Two-flop synchronizer for an active-low push-button plus registered
// falling-edge detect, producing one Press pulse per key press.
module key_press_detect (
  input  logic Clk,
  input  logic Resetn,
  input  logic Key_n,
  output logic Press
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       armed;
  logic [1:0] settle;

  // The chain resets to "released", so a key held through reset would look
  // like a fall; armed stays low until a genuine released level has been
  // observed at the synchronizer output after it has flushed its reset value.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      prev   <= 1'b1;
      armed  <= 1'b0;
      settle <= '0;
      Press  <= 1'b0;
    end else begin
      sync1  <= Key_n;
      sync2  <= sync1;
      prev   <= sync2;
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & sync2);
      Press  <= armed & prev & ~sync2;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Captures two operands from the switches on successive key presses,
// registers their carry-preserving sum and flags it with Done.
module operand_sequencer
  import lab_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             Load_n,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   Sum,
  output logic [1:0]       State,
  output logic             Done
);

  logic             press;
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH:0]   sum_nxt;
  logic             done_nxt;

  key_press_detect u_key (
    .Clk    (Clk),
    .Resetn (Resetn),
    .Key_n  (Load_n),
    .Press  (press)
  );

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = A;
    b_nxt     = B;
    sum_nxt   = Sum;
    unique case (state)
      IDLE, SHOW: begin
        if (press) begin
          a_nxt     = D;
          b_nxt     = '0;
          state_nxt = GOT_A;
        end
      end
      GOT_A: begin
        if (press) begin
          b_nxt     = D;
          state_nxt = GOT_B;
        end
      end
      GOT_B: begin
        sum_nxt   = {1'b0, A} + {1'b0, B};
        state_nxt = SHOW;
      end
    endcase
    // Done is registered from the next state so it rises and falls on the
    // same edge that enters or leaves SHOW.
    done_nxt = (state_nxt == SHOW);
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      A    <= '0;
      B    <= '0;
      Sum  <= '0;
      Done <= 1'b0;
    end else begin
      A    <= a_nxt;
      B    <= b_nxt;
      Sum  <= sum_nxt;
      Done <= done_nxt;
    end
  end

  assign State = state;

endmodule
